// File: rtl/fwft_fifo_hash.sv
// fwft_fifo_hash: first-word-fall-through FIFO front-end plus a combinational dual XOR-fold hash
// that turns a flow tuple into two Bloom-filter indices.
module fwft_fifo_hash #(
  parameter int WIDTH          = 72,
  parameter int MAX_DEPTH_BITS = 3,
  parameter int HASH_IN_WIDTH  = 128,
  parameter int HASH_OUT_WIDTH = 19
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [WIDTH-1:0]          din,
  input  logic                      wr_en,
  input  logic                      rd_en,
  output logic [WIDTH-1:0]          dout,
  output logic                      full,
  output logic                      nearly_full,
  output logic                      empty,
  input  logic [HASH_IN_WIDTH-1:0]  data,
  output logic [HASH_OUT_WIDTH-1:0] hash_0,
  output logic [HASH_OUT_WIDTH-1:0] hash_1
);
  localparam int DEPTH = 1 << MAX_DEPTH_BITS;
  localparam int CW    = MAX_DEPTH_BITS + 1;
  localparam int K     = (HASH_IN_WIDTH + HASH_OUT_WIDTH - 1) / HASH_OUT_WIDTH;
  localparam int PW    = K * HASH_OUT_WIDTH;
  logic [WIDTH-1:0]          mem [DEPTH];
  logic [MAX_DEPTH_BITS-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0]             count, count_next;
  logic                      wr_ok, rd_ok;
  logic [HASH_IN_WIDTH-1:0]  rev;
  logic [PW-1:0]             pad_0, pad_1;
  always_comb begin
    wr_ok      = wr_en && !full;
    rd_ok      = rd_en && !empty;
    count_next = count + CW'(wr_ok) - CW'(rd_ok);
  end
  // Storage is never cleared; only pointers and count are reset.
  always_ff @(posedge clk)
    if (reset && wr_ok) mem[wr_ptr] <= din;
  // Flags are registered from the next count so they move on the same edge as the access.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      full        <= 1'b0;
      nearly_full <= 1'b0;
      empty       <= 1'b1;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      count       <= count_next;
      full        <= count_next == CW'(DEPTH);
      nearly_full <= count_next >= CW'(DEPTH - 1);
      empty       <= count_next == '0;
    end
  end
  assign dout = mem[rd_ptr];
  always_comb begin
    rev    = {<<{data}};
    pad_0  = PW'(data);
    pad_1  = PW'(rev);
    hash_0 = '0;
    hash_1 = '0;
    for (int i = 0; i < K; i++) begin
      hash_0 ^= pad_0[i*HASH_OUT_WIDTH +: HASH_OUT_WIDTH];
      hash_1 ^= pad_1[i*HASH_OUT_WIDTH +: HASH_OUT_WIDTH];
    end
  end
endmodule

// File: tb/tb_fwft_fifo_hash.sv
// tb_fwft_fifo_hash: scoreboard-checked FIFO sequences and table-driven hash vectors.
module tb_fwft_fifo_hash;
  logic         clk, reset, wr_en, rd_en;
  logic [71:0]  din, dout;
  logic         full, nearly_full, empty;
  logic [127:0] data;
  logic [18:0]  hash_0, hash_1;
  logic [71:0]  sb [$];
  int checks = 0;
  int errors = 0;

  fwft_fifo_hash dut (
    .clk(clk), .reset(reset), .din(din), .wr_en(wr_en), .rd_en(rd_en), .dout(dout),
    .full(full), .nearly_full(nearly_full), .empty(empty),
    .data(data), .hash_0(hash_0), .hash_1(hash_1)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, " empty"}, 72'(empty), 72'(sb.size() == 0));
    check({tag, " full"}, 72'(full), 72'(sb.size() == 8));
    check({tag, " nearly_full"}, 72'(nearly_full), 72'(sb.size() >= 7));
    if (sb.size() > 0) check({tag, " head"}, dout, sb[0]);
  endtask

  // One clock: drive at the falling edge, update the scoreboard at the edge, check at next fall.
  task automatic step(input logic w, input logic [71:0] d, input logic r, input logic rs,
                      input string tag);
    logic wa, ra;
    if (rs && r && sb.size() > 0) check({tag, " rd data"}, dout, sb[0]);
    wr_en = w; din = d; rd_en = r; reset = rs;
    @(posedge clk);
    if (!rs) sb.delete();
    else begin
      wa = w && sb.size() < 8;
      ra = r && sb.size() > 0;
      if (ra) void'(sb.pop_front());
      if (wa) sb.push_back(d);
    end
    @(negedge clk);
    check_state(tag);
  endtask

  function automatic logic [18:0] fold(input logic [127:0] x);
    logic [18:0] r = '0;
    for (int b = 0; b < 19; b++)
      for (int j = b; j < 128; j += 19) r[b] ^= x[j];
    return r;
  endfunction

  function automatic logic [127:0] bitrev(input logic [127:0] x);
    logic [127:0] y;
    for (int j = 0; j < 128; j++) y[j] = x[127 - j];
    return y;
  endfunction

  typedef struct {
    logic [127:0] d;
    logic [18:0]  h0;
    logic [18:0]  h1;
  } hvec_t;

  initial begin
    hvec_t hv [6];
    logic [127:0] rnd;
    logic [71:0] v;
    reset = 0; wr_en = 0; rd_en = 0; din = '0; data = '0;
    hv[0] = '{128'd0, 19'h00000, 19'h00000};
    hv[1] = '{128'd1, 19'h00001, 19'h02000};
    hv[2] = '{{128{1'b1}}, 19'h03FFF, 19'h03FFF};
    for (int i = 3; i < 6; i++) begin
      rnd = {$urandom, $urandom, $urandom, $urandom};
      hv[i] = '{rnd, fold(rnd), fold(bitrev(rnd))};
    end
    @(negedge clk);
    step(0, '0, 0, 0, "reset0");
    step(0, '0, 0, 0, "reset1");
    step(0, '0, 1, 1, "rd_empty");
    step(0, '0, 0, 1, "idle");
    for (int i = 1; i <= 8; i++) step(1, 72'(i), 0, 1, "fill");
    step(1, 72'hFF, 0, 1, "wr_full");
    step(1, 72'hEE, 1, 1, "rdwr_full");
    step(1, 72'h09, 0, 1, "refill");
    for (int i = 0; i < 9; i++) step(0, '0, 1, 1, "drain");
    step(0, '0, 1, 1, "rd_empty2");
    step(1, 72'hAB, 0, 1, "fwft_wr");
    for (int i = 0; i < 3; i++) step(0, '0, 0, 1, "fwft_hold");
    step(0, '0, 1, 1, "fwft_rd");
    for (int i = 0; i < 3; i++) step(1, 72'(100 + i), 0, 1, "lvl3");
    for (int i = 0; i < 20; i++) begin
      v = {8'hC3, 64'(200 + i)};
      step(1, v, 1, 1, "rdwr3");
    end
    step(1, 72'h55, 1, 0, "mid_reset");
    step(0, '0, 0, 1, "post_reset");
    for (int i = 0; i < 6; i++) begin
      data = hv[i].d;
      #1;
      check("hash_0", 72'(hash_0), 72'(hv[i].h0));
      check("hash_1", 72'(hash_1), 72'(hv[i].h1));
    end
    reset = 0;
    @(negedge clk);
    data = hv[1].d;
    #2;
    check("hash_0 in reset", 72'(hash_0), 72'(hv[1].h0));
    data = hv[2].d;
    #2;
    check("hash_1 in reset", 72'(hash_1), 72'(hv[2].h1));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
